// File: rtl/pinfilter_ctrl.sv
// Sample-tick prescaler, strobe filter and capture sequencer for the cartridge-bus pin-filter bank.
// Optional settle timeout with cap_err output: define PINFILTER_CTRL_TIMEOUT_EN.
module pinfilter_ctrl #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIV    = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             raw_strb,
    input  logic [WIDTH-1:0] raw_bus,
    output logic             ena_out,
    output logic             strb_filt,
    output logic             cap_valid,
    input  logic             cap_ready,
    output logic [WIDTH-1:0] cap_data,
    output logic             busy,
    output logic             overrun,
    output logic             glitch
`ifdef PINFILTER_CTRL_TIMEOUT_EN
    ,
    output logic             cap_err
`endif
);
    localparam int unsigned   CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD, S_WAIT_REL} state_t;
    state_t state, state_nx;

    logic [CW-1:0]    pre_cnt;
    logic [1:0]       spipe;
    logic             sprev;
    logic [WIDTH-1:0] bpipe0, bpipe1;
    logic [3:0]       settle_cnt, settle_nx;
    logic             cap_valid_nx, glitch_nx, overrun_nx;
    logic [WIDTH-1:0] cap_data_nx;
    logic             fall;
`ifdef PINFILTER_CTRL_TIMEOUT_EN
    logic [3:0]       retry_cnt, retry_nx;
    logic             cap_err_nx;
`endif

    assign ena_out = (pre_cnt == CNT_LAST);
    assign busy    = (state != S_IDLE);
    // A fall is a 1->0 change between the filtered levels seen at consecutive ticks.
    assign fall    = ena_out && sprev && !strb_filt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt   <= '0;
            spipe     <= 2'b11;
            strb_filt <= 1'b1;
            sprev     <= 1'b1;
            bpipe0    <= '0;
            bpipe1    <= '0;
        end else begin
            pre_cnt <= ena_out ? '0 : pre_cnt + 1'b1;
            if (ena_out) begin
                spipe <= {spipe[0], raw_strb};
                if (spipe == 2'b00)
                    strb_filt <= 1'b0;
                else if (spipe == 2'b11)
                    strb_filt <= 1'b1;
                sprev  <= strb_filt;
                bpipe1 <= bpipe0;
                bpipe0 <= raw_bus;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            cap_valid  <= 1'b0;
            cap_data   <= '0;
            glitch     <= 1'b0;
            overrun    <= 1'b0;
`ifdef PINFILTER_CTRL_TIMEOUT_EN
            retry_cnt  <= '0;
            cap_err    <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            settle_cnt <= settle_nx;
            cap_valid  <= cap_valid_nx;
            cap_data   <= cap_data_nx;
            glitch     <= glitch_nx;
            overrun    <= overrun_nx;
`ifdef PINFILTER_CTRL_TIMEOUT_EN
            retry_cnt  <= retry_nx;
            cap_err    <= cap_err_nx;
`endif
        end
    end

    always_comb begin
        state_nx     = state;
        settle_nx    = settle_cnt;
        cap_valid_nx = cap_valid;
        cap_data_nx  = cap_data;
        glitch_nx    = 1'b0;
        overrun_nx   = overrun;
`ifdef PINFILTER_CTRL_TIMEOUT_EN
        retry_nx     = retry_cnt;
        cap_err_nx   = cap_err;
`endif
        unique case (state)
            S_IDLE: begin
                if (fall) begin
                    settle_nx = 4'(SETTLE);
                    state_nx  = S_SETTLE;
`ifdef PINFILTER_CTRL_TIMEOUT_EN
                    retry_nx  = '0;
`endif
                end
            end
            S_SETTLE: begin
                if (ena_out) begin
                    if (strb_filt) begin
                        glitch_nx = 1'b1;
                        state_nx  = S_IDLE;
                    end else if (settle_cnt != '0) begin
                        settle_nx = settle_cnt - 4'd1;
                    end else if (bpipe0 == bpipe1) begin
                        cap_data_nx  = bpipe0;
                        cap_valid_nx = 1'b1;
                        state_nx     = S_HOLD;
`ifdef PINFILTER_CTRL_TIMEOUT_EN
                        cap_err_nx   = 1'b0;
                    end else if (retry_cnt == 4'hF) begin
                        cap_data_nx  = bpipe0;
                        cap_valid_nx = 1'b1;
                        cap_err_nx   = 1'b1;
                        state_nx     = S_HOLD;
                    end else begin
                        retry_nx = retry_cnt + 4'd1;
`endif
                    end
                end
            end
            S_HOLD: begin
                if (fall)
                    overrun_nx = 1'b1;
                if (cap_valid && cap_ready) begin
                    cap_valid_nx = 1'b0;
                    state_nx     = S_WAIT_REL;
`ifdef PINFILTER_CTRL_TIMEOUT_EN
                    cap_err_nx   = 1'b0;
`endif
                end
            end
            S_WAIT_REL: begin
                if (strb_filt)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_pinfilter_ctrl.sv
// Self-checking bench for pinfilter_ctrl: directed scenarios plus randomized strobe/data traffic
// compared clock-by-clock against a tick-history reference model.
module tb_pinfilter_ctrl;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DIV    = 4;
    localparam int unsigned SETTLE = 2;
    localparam logic [13:0] RST_VEC = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             raw_strb = 1'b1;
    logic [WIDTH-1:0] raw_bus = '0;
    logic             cap_ready = 1'b0;
    logic             ena_out, strb_filt, cap_valid, busy, overrun, glitch;
    logic [WIDTH-1:0] cap_data;
`ifdef PINFILTER_CTRL_TIMEOUT_EN
    logic             cap_err;
`endif

    pinfilter_ctrl #(.WIDTH(WIDTH), .DIV(DIV), .SETTLE(SETTLE)) dut (
        .clk(clk), .reset_n(reset_n), .raw_strb(raw_strb), .raw_bus(raw_bus),
        .ena_out(ena_out), .strb_filt(strb_filt), .cap_valid(cap_valid), .cap_ready(cap_ready),
        .cap_data(cap_data), .busy(busy), .overrun(overrun), .glitch(glitch)
`ifdef PINFILTER_CTRL_TIMEOUT_EN
        , .cap_err(cap_err)
`endif
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: keeps the raw samples and filtered levels seen at each tick.
    typedef enum {M_IDLE, M_SETTLE, M_HOLD, M_WAIT} mmode_t;
    mmode_t     m_mode;
    int         m_edges, m_left, m_retry;
    bit         m_filt, m_valid, m_over, m_glitch, m_err;
    logic [7:0] m_data;
    bit         m_sq[$];
    bit         m_fh[$];
    logic [7:0] m_bq[$];

    function automatic void model_reset();
        m_edges = 0; m_mode = M_IDLE; m_left = 0; m_retry = 0;
        m_filt = 1'b1; m_valid = 1'b0; m_over = 1'b0; m_glitch = 1'b0; m_err = 1'b0;
        m_data = 8'h00;
        m_sq.delete(); m_sq.push_back(1'b1); m_sq.push_back(1'b1);
        m_fh.delete(); m_fh.push_back(1'b1);
        m_bq.delete(); m_bq.push_back(8'h00); m_bq.push_back(8'h00);
    endfunction

    function automatic void model_edge(input bit strb, input logic [7:0] bus, input bit rdy);
        bit tick, fb, fell;
        logic [7:0] b0, b1;
        tick = (m_edges % DIV) == (DIV - 1);
        fb = m_filt;
        fell = 1'b0;
        m_glitch = 1'b0;
        b0 = m_bq[1];
        b1 = m_bq[0];
        if (tick) begin
            m_fh.push_back(fb);
            if (m_fh.size() > 2) void'(m_fh.pop_front());
            fell = m_fh[0] && !m_fh[1];
            if (m_sq[0] == m_sq[1]) m_filt = m_sq[1];
            m_sq.push_back(strb); void'(m_sq.pop_front());
            m_bq.push_back(bus);  void'(m_bq.pop_front());
        end
        case (m_mode)
            M_IDLE: if (tick && fell) begin m_mode = M_SETTLE; m_left = SETTLE; m_retry = 0; end
            M_SETTLE: if (tick) begin
                if (fb) begin m_glitch = 1'b1; m_mode = M_IDLE; end
                else if (m_left > 0) m_left--;
                else if (b0 == b1) begin m_data = b0; m_valid = 1'b1; m_err = 1'b0; m_mode = M_HOLD; end
`ifdef PINFILTER_CTRL_TIMEOUT_EN
                else if (m_retry == 15) begin m_data = b0; m_valid = 1'b1; m_err = 1'b1; m_mode = M_HOLD; end
                else m_retry++;
`endif
            end
            M_HOLD: begin
                if (tick && fell) m_over = 1'b1;
                if (rdy) begin m_valid = 1'b0; m_err = 1'b0; m_mode = M_WAIT; end
            end
            default: if (fb) m_mode = M_IDLE;
        endcase
        m_edges++;
    endfunction

    function automatic logic [13:0] exp_vec();
        return {((m_edges % DIV) == (DIV - 1)), m_filt, m_valid, (m_mode != M_IDLE), m_over, m_glitch, m_data};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {ena_out, strb_filt, cap_valid, busy, overrun, glitch, cap_data};
    endfunction

    int          obs_ena, obs_valid, obs_words, obs_glitch, obs_busy, obs_filt_low, adv_bad;
    logic [7:0]  obs_word;
    logic [13:0] adv_act, adv_req;

    task automatic clear_obs();
        obs_ena = 0; obs_valid = 0; obs_words = 0; obs_glitch = 0; obs_busy = 0;
        obs_filt_low = 0; adv_bad = 0; obs_word = 8'hxx;
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) begin
            if (cap_valid && cap_ready) begin obs_words++; obs_word = cap_data; end
            @(posedge clk);
            if (!reset_n) model_reset();
            else model_edge(raw_strb, raw_bus, cap_ready);
            #1;
            if (ena_out)    obs_ena++;
            if (cap_valid)  obs_valid++;
            if (glitch)     obs_glitch++;
            if (busy)       obs_busy++;
            if (!strb_filt) obs_filt_low++;
            if (dut_vec() !== exp_vec()) begin
                if (adv_bad == 0) begin adv_act = dut_vec(); adv_req = exp_vec(); end
                adv_bad++;
            end
        end
    endtask

    task automatic ticks(input int n);
        advance(n * DIV);
    endtask

    task automatic to_tick();
        while ((m_edges % DIV) != 0) advance(1);
    endtask

    task automatic toggle_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            raw_bus = (raw_bus == 8'h00) ? 8'hFF : 8'h00;
            ticks(1);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; raw_strb = 1'b1; raw_bus = 8'h00; cap_ready = 1'b0;
        clear_obs();
        advance(3);
        tests_run++;
        if (dut_vec() !== RST_VEC) begin tests_failed++; $display("FAIL reset_values: got %h want %h", dut_vec(), RST_VEC); end
        reset_n = 1'b1;
        clear_obs();
        advance(12);
        tests_run++;
        if (obs_ena != 3) begin tests_failed++; $display("FAIL ena_pulses: got %0d want 3", obs_ena); end
        tests_run++;
        if (adv_bad != 0) begin tests_failed++; $display("FAIL reset_trace: %0d clks off, first got %h want %h", adv_bad, adv_act, adv_req); end
    endtask

    task automatic test_clean();
        to_tick(); clear_obs();
        raw_bus = 8'hA5; cap_ready = 1'b1; raw_strb = 1'b0;
        ticks(2);
        tests_run++;
        if (strb_filt !== 1'b1) begin tests_failed++; $display("FAIL clean_filt_t2: got %b want 1", strb_filt); end
        ticks(1);
        tests_run++;
        if (strb_filt !== 1'b0) begin tests_failed++; $display("FAIL clean_filt_t3: got %b want 0", strb_filt); end
        ticks(9);
        raw_strb = 1'b1;
        ticks(3);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL clean_busy_rel: got %b want 1", busy); end
        advance(1);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL clean_idle: got %b want 0", busy); end
        ticks(2);
        tests_run++;
        if (obs_valid != 1 || obs_words != 1 || obs_word !== 8'hA5)
            begin tests_failed++; $display("FAIL clean_word: got valid_clks=%0d words=%0d data=%h want 1 1 a5", obs_valid, obs_words, obs_word); end
        tests_run++;
        if (adv_bad != 0) begin tests_failed++; $display("FAIL clean_trace: %0d clks off, first got %h want %h", adv_bad, adv_act, adv_req); end
    endtask

    task automatic test_glitch();
        to_tick(); clear_obs();
        raw_strb = 1'b0; ticks(1);
        raw_strb = 1'b1; ticks(6);
        tests_run++;
        if (obs_busy != 0 || obs_filt_low != 0)
            begin tests_failed++; $display("FAIL glitch_short: got busy_clks=%0d filt_low_clks=%0d want 0 0", obs_busy, obs_filt_low); end
        clear_obs();
        raw_strb = 1'b0; ticks(3);
        raw_strb = 1'b1; ticks(8);
        tests_run++;
        if (obs_glitch != 1 || obs_valid != 0)
            begin tests_failed++; $display("FAIL glitch_pulse: got glitches=%0d valid_clks=%0d want 1 0", obs_glitch, obs_valid); end
        tests_run++;
        if (adv_bad != 0) begin tests_failed++; $display("FAIL glitch_trace: %0d clks off, first got %h want %h", adv_bad, adv_act, adv_req); end
    endtask

    task automatic test_unstable();
        to_tick(); clear_obs();
        cap_ready = 1'b1; raw_bus = 8'hFF; raw_strb = 1'b0;
        toggle_ticks(10);
        raw_bus = 8'h3C;
        ticks(2);
        tests_run++;
        if (obs_valid != 0) begin tests_failed++; $display("FAIL unstable_early: got valid_clks=%0d want 0", obs_valid); end
        ticks(1);
        tests_run++;
        if (cap_valid !== 1'b1 || cap_data !== 8'h3C)
            begin tests_failed++; $display("FAIL unstable_cap: got valid=%b data=%h want 1 3c", cap_valid, cap_data); end
        ticks(3);
        raw_strb = 1'b1;
        ticks(6);
        tests_run++;
        if (adv_bad != 0) begin tests_failed++; $display("FAIL unstable_trace: %0d clks off, first got %h want %h", adv_bad, adv_act, adv_req); end
    endtask

`ifdef PINFILTER_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        to_tick(); clear_obs();
        cap_ready = 1'b0; raw_bus = 8'h00; raw_strb = 1'b0;
        toggle_ticks(30);
        tests_run++;
        if (cap_valid !== 1'b1 || cap_err !== 1'b1)
            begin tests_failed++; $display("FAIL timeout_cap: got valid=%b err=%b want 1 1", cap_valid, cap_err); end
        cap_ready = 1'b1; advance(2);
        raw_strb = 1'b1; ticks(6);
        tests_run++;
        if (adv_bad != 0) begin tests_failed++; $display("FAIL timeout_trace: %0d clks off, first got %h want %h", adv_bad, adv_act, adv_req); end
    endtask
`else
    task automatic test_no_timeout();
        to_tick(); clear_obs();
        cap_ready = 1'b1; raw_bus = 8'h00; raw_strb = 1'b0;
        toggle_ticks(40);
        tests_run++;
        if (obs_valid != 0 || busy !== 1'b1)
            begin tests_failed++; $display("FAIL nto_wait: got valid_clks=%0d busy=%b want 0 1", obs_valid, busy); end
        raw_strb = 1'b1;
        toggle_ticks(5);
        tests_run++;
        if (obs_glitch != 1 || busy !== 1'b0)
            begin tests_failed++; $display("FAIL nto_release: got glitches=%0d busy=%b want 1 0", obs_glitch, busy); end
        tests_run++;
        if (adv_bad != 0) begin tests_failed++; $display("FAIL nto_trace: %0d clks off, first got %h want %h", adv_bad, adv_act, adv_req); end
    endtask
`endif

    task automatic test_backpressure();
        to_tick(); clear_obs();
        cap_ready = 1'b0; raw_bus = 8'h5A; raw_strb = 1'b0;
        ticks(10);
        raw_strb = 1'b1; ticks(4);
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL bp_no_overrun: got %b want 0", overrun); end
        raw_bus = 8'h77; raw_strb = 1'b0; ticks(6);
        tests_run++;
        if (cap_valid !== 1'b1 || cap_data !== 8'h5A || overrun !== 1'b1)
            begin tests_failed++; $display("FAIL bp_held: got valid=%b data=%h overrun=%b want 1 5a 1", cap_valid, cap_data, overrun); end
        cap_ready = 1'b1; advance(2);
        raw_strb = 1'b1; ticks(6);
        tests_run++;
        if (obs_words != 1 || obs_word !== 8'h5A || overrun !== 1'b1 || busy !== 1'b0)
            begin tests_failed++; $display("FAIL bp_deliver: got words=%0d data=%h overrun=%b busy=%b want 1 5a 1 0", obs_words, obs_word, overrun, busy); end
        tests_run++;
        if (adv_bad != 0) begin tests_failed++; $display("FAIL bp_trace: %0d clks off, first got %h want %h", adv_bad, adv_act, adv_req); end
    endtask

    task automatic test_random();
        int lo, hi, bmode, rmode;
        to_tick(); clear_obs();
        for (int seg = 0; seg < 40; seg++) begin
            lo = int'($urandom_range(12, 0));
            hi = int'($urandom_range(6, 1));
            bmode = int'($urandom_range(2, 0));
            rmode = int'($urandom_range(3, 0));
            raw_strb = 1'b0;
            for (int t = 0; t < lo + hi; t++) begin
                if (t == lo) raw_strb = 1'b1;
                if (bmode == 1 || (bmode == 2 && $urandom_range(3, 0) == 0)) raw_bus = 8'($urandom);
                for (int c = 0; c < int'(DIV); c++) begin
                    cap_ready = (rmode != 0) && ($urandom_range(3, 0) != 0);
                    advance(1);
                end
            end
        end
        raw_strb = 1'b1; cap_ready = 1'b1;
        ticks(8);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL rand_drain: got busy=%b want 0", busy); end
        tests_run++;
        if (adv_bad != 0) begin tests_failed++; $display("FAIL rand_trace: %0d clks off, first got %h want %h", adv_bad, adv_act, adv_req); end
    endtask

    task automatic test_reset_mid();
        to_tick(); clear_obs();
        cap_ready = 1'b0; raw_bus = 8'hC3; raw_strb = 1'b0;
        ticks(9);
        tests_run++;
        if (cap_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_pending: got valid=%b want 1", cap_valid); end
        reset_n = 1'b0; raw_strb = 1'b1;
        #2;
        tests_run++;
        if (dut_vec() !== RST_VEC) begin tests_failed++; $display("FAIL mid_async_reset: got %h want %h", dut_vec(), RST_VEC); end
        model_reset();
        advance(2);
        reset_n = 1'b1;
        clear_obs();
        advance(8 * DIV);
        tests_run++;
        if (obs_valid != 0 || adv_bad != 0)
            begin tests_failed++; $display("FAIL mid_after: valid_clks=%0d, %0d clks off, first got %h want %h", obs_valid, adv_bad, adv_act, adv_req); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean();
        test_glitch();
        test_unstable();
`ifdef PINFILTER_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
